// File: rtl/des_pkg.sv
// DES permutation tables and the shared bit-permutation helper.
// Tables use FIPS 46-3 numbering: DES bit n is vector bit [64-n], so DES bit 1 is the MSB.
package des_pkg;

    typedef logic [63:0] des_blk_t;

    localparam int DES_IP [1:64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int DES_FP [1:64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    // mode=0 applies IP, mode=1 applies IP^-1; output DES bit i = input DES bit TABLE[i].
    function automatic des_blk_t des_permute(input des_blk_t blk, input logic mode);
        des_blk_t   res;
        int         src;
        logic [5:0] w_dst;
        logic [5:0] w_src;
        res = '0;
        for (int i = 1; i <= 64; i++) begin
            src      = mode ? DES_FP[i] : DES_IP[i];
            w_dst    = 6'(64 - i);
            w_src    = 6'(64 - src);
            res[w_dst] = blk[w_src];
        end
        return res;
    endfunction

endpackage

// File: rtl/des_perm_lane.sv
// One combinational 64-bit DES permutation lane, IP or IP^-1 selected by i_mode.
module des_perm_lane
    import des_pkg::*;
(
    input  logic     i_mode,
    input  des_blk_t i_blk,
    output des_blk_t o_blk
);

    assign o_blk = des_permute(i_blk, i_mode);

endmodule

// File: rtl/des_perm_pipe.sv
// Pipelined DES IP / IP^-1 engine over LANES blocks per beat, with tag sideband,
// valid/ready flow control on both ends and a wrapping completed-beat counter.
module des_perm_pipe
    import des_pkg::*;
#(
    parameter int LANES       = 1,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [TAG_W-1:0]      in_tag,
    input  logic [64*LANES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_mode,
    output logic [TAG_W-1:0]      out_tag,
    output logic [64*LANES-1:0]   out_data,
    output logic [CNT_W-1:0]      beat_cnt
);

    localparam int DW = 64 * LANES;

    logic [DW-1:0]    w_perm;
    logic             r_v    [PIPE_STAGES];
    logic             r_mode [PIPE_STAGES];
    logic [TAG_W-1:0] r_tag  [PIPE_STAGES];
    logic [DW-1:0]    r_data [PIPE_STAGES];
    logic             w_adv  [PIPE_STAGES];
    logic             w_load [PIPE_STAGES];
    logic [CNT_W-1:0] r_cnt;
    logic             w_in_fire;
    logic             w_out_fire;

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            des_perm_lane u_lane (
                .i_mode (in_mode),
                .i_blk  (in_data[64*k +: 64]),
                .o_blk  (w_perm[64*k +: 64])
            );
        end
    endgenerate

    // A stage advances when it holds a beat and its successor can load; it loads
    // when empty or advancing, so bubbles collapse regardless of out_ready.
    genvar s;
    generate
        for (s = 0; s < PIPE_STAGES; s++) begin : g_ctl
            if (s == PIPE_STAGES - 1) begin : g_last
                assign w_adv[s] = r_v[s] & out_ready;
            end else begin : g_mid
                assign w_adv[s] = r_v[s] & w_load[s+1];
            end
            assign w_load[s] = ~r_v[s] | w_adv[s];
        end
    endgenerate

    // Handshake: a beat moves on valid & ready; out_* hold while out_valid & !out_ready.
    assign in_ready   = ~rst & w_load[0];
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = w_adv[PIPE_STAGES-1] & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                r_v[i]    <= 1'b0;
                r_mode[i] <= 1'b0;
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
            r_cnt <= '0;
        end else begin
            if (w_load[0]) begin
                r_v[0] <= w_in_fire;
            end
            if (w_in_fire) begin
                r_mode[0] <= in_mode;
                r_tag[0]  <= in_tag;
                r_data[0] <= w_perm;
            end
            for (int i = 1; i < PIPE_STAGES; i++) begin
                if (w_load[i]) begin
                    r_v[i] <= r_v[i-1];
                    if (r_v[i-1]) begin
                        r_mode[i] <= r_mode[i-1];
                        r_tag[i]  <= r_tag[i-1];
                        r_data[i] <= r_data[i-1];
                    end
                end
            end
            if (w_out_fire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = r_v[PIPE_STAGES-1];
    assign out_mode  = r_mode[PIPE_STAGES-1];
    assign out_tag   = r_tag[PIPE_STAGES-1];
    assign out_data  = r_data[PIPE_STAGES-1];
    assign beat_cnt  = r_cnt;

endmodule
